// File: rtl/shift_accumulator.sv
// Neuron accumulator: sums signed shifted terms into a saturating ACC_W register and presents
// a DATA_W-clipped sum via valid/ready. Define SHIFT_ACC_RELU_EN to apply ReLU to out_sum.
module shift_accumulator #(
    parameter int DATA_W    = 32,
    parameter int ACC_W     = 40,
    parameter int MAX_TERMS = 64,
    parameter int CNT_W     = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_sat,
    output logic              out_len_err,
    output logic              out_valid,
    input  logic              out_ready
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    state_e                    state_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic [CNT_W-1:0]          cnt_q;
    logic                      sat_q;
    logic [DATA_W-1:0]         sum_q;
    logic [CNT_W-1:0]          count_q;
    logic                      osat_q;
    logic                      len_err_q;

    logic                      take;
    logic                      start;
    logic signed [ACC_W-1:0]   base_acc;
    logic [CNT_W-1:0]          base_cnt;
    logic                      base_sat;
    logic signed [ACC_W:0]     sum_x;
    logic                      ovf;
    logic signed [ACC_W-1:0]   acc_d;
    logic [CNT_W-1:0]          cnt_d;
    logic                      sat_d;
    logic                      hit_max;
    logic                      close;
    logic                      clip_hi;
    logic                      clip_lo;
    logic [DATA_W-1:0]         clip_val;
    logic [DATA_W-1:0]         sum_d;

    assign in_ready = (state_q != DONE) || out_ready;
    assign take     = in_valid && in_ready;
    // Any take outside ACCUM begins a fresh sum (IDLE, or DONE fast path on handshake).
    assign start    = (state_q != ACCUM);

    always_comb begin
        base_acc = start ? '0 : acc_q;
        base_cnt = start ? '0 : cnt_q;
        base_sat = start ? 1'b0 : sat_q;
        sum_x    = {base_acc[ACC_W-1], base_acc}
                 + {{(ACC_W+1-DATA_W){in_data[DATA_W-1]}}, in_data};
        ovf      = sum_x[ACC_W] != sum_x[ACC_W-1];
        acc_d    = ovf ? (sum_x[ACC_W] ? ACC_MIN : ACC_MAX) : sum_x[ACC_W-1:0];
        sat_d    = base_sat | ovf;
        cnt_d    = base_cnt + CNT_W'(1);
        hit_max  = (cnt_d == CNT_W'(MAX_TERMS));
        close    = in_last || hit_max;
        clip_hi  = acc_d > OUT_MAX;
        clip_lo  = acc_d < OUT_MIN;
        clip_val = clip_hi ? {1'b0, {(DATA_W-1){1'b1}}} :
                   clip_lo ? {1'b1, {(DATA_W-1){1'b0}}} : acc_d[DATA_W-1:0];
`ifdef SHIFT_ACC_RELU_EN
        sum_d    = clip_val[DATA_W-1] ? '0 : clip_val;
`else
        sum_d    = clip_val;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
            sum_q     <= '0;
            count_q   <= '0;
            osat_q    <= 1'b0;
            len_err_q <= 1'b0;
        end else if (take) begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            sat_q <= sat_d;
            if (close) begin
                state_q   <= DONE;
                sum_q     <= sum_d;
                count_q   <= cnt_d;
                osat_q    <= sat_d | clip_hi | clip_lo;
                len_err_q <= !in_last && hit_max;
            end else begin
                state_q <= ACCUM;
            end
        end else if (state_q == DONE && out_ready) begin
            state_q <= IDLE;
        end
    end

    assign out_valid   = (state_q == DONE);
    assign out_sum     = sum_q;
    assign out_count   = count_q;
    assign out_sat     = osat_q;
    assign out_len_err = len_err_q;

endmodule

// File: tb/tb_shift_accumulator.sv
// Bench for shift_accumulator: table vectors, directed corner sequences and a randomized
// scoreboard run against a behavioural model of the saturating sum.
module tb_shift_accumulator;

    localparam int  MAXT = 64;
    localparam longint AMAX = (longint'(1) <<< 39) - 1;
    localparam longint AMIN = -(longint'(1) <<< 39);
    localparam longint OMAX = 64'sd2147483647;
    localparam longint OMIN = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic [31:0] out_sum;
    logic [6:0]  out_count;
    logic        out_sat;
    logic        out_len_err;
    logic        out_valid;
    logic        out_ready = 1'b1;

    always #5 clk = ~clk;

    shift_accumulator dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_sum(out_sum), .out_count(out_count), .out_sat(out_sat),
        .out_len_err(out_len_err), .out_valid(out_valid), .out_ready(out_ready)
    );

    typedef struct {
        longint sum;
        int     cnt;
        bit     sat;
        bit     len;
    } exp_t;

    typedef struct {
        int     t[4];
        int     n;
        longint sum;
        int     cnt;
        bit     sat;
    } vec_t;

    exp_t   sbq[$];
    int     n_cmp = 0;
    int     n_err = 0;
    longint m_acc = 0;
    int     m_cnt = 0;
    bit     m_sat = 0;
    bit     push_model = 1;
    bit     rand_rdy = 0;

    function automatic longint fin(input longint s);
`ifdef SHIFT_ACC_RELU_EN
        return (s < 0) ? 64'sd0 : s;
`else
        return s;
`endif
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_take(input int d, input bit last);
        exp_t   e;
        longint c;
        if (m_cnt == 0) begin
            m_acc = 0;
            m_sat = 0;
        end
        m_acc = m_acc + longint'(d);
        if (m_acc > AMAX) begin m_acc = AMAX; m_sat = 1; end
        if (m_acc < AMIN) begin m_acc = AMIN; m_sat = 1; end
        m_cnt++;
        if (last || m_cnt == MAXT) begin
            c = m_acc;
            e.sat = m_sat;
            if (c > OMAX) begin c = OMAX; e.sat = 1; end
            if (c < OMIN) begin c = OMIN; e.sat = 1; end
            e.sum = fin(c);
            e.cnt = m_cnt;
            e.len = !last;
            if (push_model) sbq.push_back(e);
            m_cnt = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Holds a beat until accepted; the accept decision is sampled at the negedge before the edge.
    task automatic send_beat(input int d, input bit last);
        bit taken = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        for (int i = 0; i < 200 && !taken; i++) begin
            @(negedge clk);
            if (in_ready) begin
                taken = 1;
                model_take(d, last);
            end
            tick();
        end
        if (!taken) begin
            n_cmp++;
            n_err++;
            $display("FAIL beat_timeout: got no accept expected accept of %0d", d);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_result: got sum %0d expected none", $signed(out_sum));
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("sb_sum", longint'($signed(out_sum)), e.sum);
                chk("sb_count", longint'(out_count), longint'(e.cnt));
                chk("sb_sat", longint'(out_sat), longint'(e.sat));
                chk("sb_len_err", longint'(out_len_err), longint'(e.len));
            end
        end
    end

    vec_t tbl[6];

    initial begin
        tbl[0] = '{t: '{5, -3, 10, 0}, n: 3, sum: 12, cnt: 3, sat: 0};
        tbl[1] = '{t: '{int'(32'h7fff_ffff), int'(32'h7fff_ffff), 0, 0}, n: 2, sum: OMAX, cnt: 2, sat: 1};
        tbl[2] = '{t: '{-8, 2, 0, 0}, n: 2, sum: -6, cnt: 2, sat: 0};
        tbl[3] = '{t: '{7, 0, 0, 0}, n: 1, sum: 7, cnt: 1, sat: 0};
        tbl[4] = '{t: '{int'(32'h8000_0000), -1, 0, 0}, n: 2, sum: OMIN, cnt: 2, sat: 1};
        tbl[5] = '{t: '{1000, -3000, 500, 0}, n: 4, sum: -1500, cnt: 4, sat: 0};

        // Reset state
        #2 rst_n = 1'b0;
        #10;
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_sum", longint'(out_sum), 0);
        chk("rst_out_count", longint'(out_count), 0);
        chk("rst_out_sat", longint'(out_sat), 0);
        chk("rst_out_len_err", longint'(out_len_err), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", longint'(in_ready), 1);
        tick();

        // Latency: result one cycle after the final take, IDLE the cycle after
        send_beat(5, 0);
        send_beat(-3, 0);
        send_beat(10, 1);
        @(negedge clk);
        chk("lat_out_valid", longint'(out_valid), 1);
        tick();
        @(negedge clk);
        chk("idle_out_valid", longint'(out_valid), 0);
        chk("idle_in_ready", longint'(in_ready), 1);
        tick();

        // Table vectors, back-to-back through the DONE fast path
        push_model = 0;
        for (int k = 0; k < 6; k++) begin
            exp_t e;
            e.sum = fin(tbl[k].sum);
            e.cnt = tbl[k].cnt;
            e.sat = tbl[k].sat;
            e.len = 0;
            sbq.push_back(e);
            for (int j = 0; j < tbl[k].n; j++) send_beat(tbl[k].t[j], j == tbl[k].n - 1);
        end
        push_model = 1;
        tick();
        tick();

        // Forced close at MAX_TERMS, then a stalled beat while the result is held
        out_ready = 1'b0;
        for (int j = 0; j < MAXT; j++) send_beat(1, 0);
        in_valid = 1'b1;
        in_data  = 1;
        in_last  = 1'b0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            chk("stall_in_ready", longint'(in_ready), 0);
            chk("stall_out_valid", longint'(out_valid), 1);
            chk("stall_out_sum", longint'(out_sum), 64);
            chk("stall_out_count", longint'(out_count), 64);
            chk("stall_len_err", longint'(out_len_err), 1);
            tick();
        end
        out_ready = 1'b1;
        send_beat(7, 1);
        @(negedge clk);
        chk("fast_out_valid", longint'(out_valid), 1);
        chk("fast_out_count", longint'(out_count), 1);
        tick();

        // Asynchronous reset mid-sum discards the partial sum
        send_beat(100, 0);
        send_beat(200, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_out_sum", longint'(out_sum), 0);
        chk("async_out_count", longint'(out_count), 0);
        chk("async_out_valid", longint'(out_valid), 0);
        m_cnt = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        send_beat(4, 0);
        send_beat(4, 1);
        tick();

        // Random sums with valid/ready gaps
        rand_rdy = 1;
        for (int s = 0; s < 1000; s++) begin
            int n;
            bit long_run;
            long_run = ($urandom_range(0, 39) == 0);
            n = long_run ? MAXT : int'($urandom_range(1, 8));
            for (int j = 0; j < n; j++) begin
                int d;
                bit last;
                if ($urandom_range(0, 3) == 0) tick();
                d = ($urandom_range(0, 3) == 0) ? int'($urandom)
                                                : int'($urandom_range(0, 2000)) - 1000;
                last = (j == n - 1) && (!long_run || $urandom_range(0, 1) == 1);
                send_beat(d, last);
            end
        end

        rand_rdy  = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 100 && sbq.size() != 0; i++) tick();
        tick();
        chk("drain_queue_empty", longint'(sbq.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
